// File: rtl/conv_wb_bridge.sv
// Wishbone slave front end for the convolution accelerator: register file, RAM
// write/read ports and engine start/soft-reset/done sequencing behind an ack FSM.
module conv_wb_bridge #(
  parameter logic [7:0] MY_ADDR  = 8'h30,
  parameter int         ADDR_MSB = 32,
  parameter int         ADDR_LSB = 24,
  parameter int         BANK_LSB = 8,
  parameter int         IMG_DW   = 24,
  parameter int         RAM_AW   = 6,
  parameter int         RSLT_DW  = 8,
  parameter int         RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  output logic                img_we,
  output logic                kern_we,
  output logic [RAM_AW-1:0]   ram_wadr,
  output logic [IMG_DW-1:0]   ram_wdat,
  output logic [RAM_AW-1:0]   res_radr,
  input  logic [RSLT_DW-1:0]  res_rdat,
  output logic                eng_start,
  output logic                eng_soft_reset,
  input  logic                eng_done,
  output logic [31:0]         cfg0,
  output logic [31:0]         cfg1,
  output logic                irq
);

  localparam int WIN_W = ADDR_MSB - ADDR_LSB;
  localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_ACK} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdat_q, rdat_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               irq_en_q, irq_en_d;
  logic [31:0]        cfg0_q, cfg0_d;
  logic [31:0]        cfg1_q, cfg1_d;

  logic        acc, wr, rd;
  logic [1:0]  bank, rword;
  logic        ctrl_wr, stat_wr, cfg0_wr, cfg1_wr;
  logic        soft_req, start_req, err_set;
  logic [31:0] reg_rdat, res_ext;
  logic        unused_adr;

  assign unused_adr = ^wbs_adr_i;

  always_comb begin
    bank  = wbs_adr_i[BANK_LSB+1:BANK_LSB];
    rword = wbs_adr_i[3:2];
    // Transactions are only taken in IDLE; reset suppresses every side effect.
    acc = (wbs_adr_i[ADDR_MSB-1:ADDR_LSB] == WIN_W'(MY_ADDR)) & wbs_cyc_i & wbs_stb_i
          & (state_q == S_IDLE) & ~reset;
    wr  = acc & wbs_we_i;
    rd  = acc & ~wbs_we_i;

    ctrl_wr = wr & (bank == 2'd0) & (rword == 2'd0) & wbs_sel_i[0];
    stat_wr = wr & (bank == 2'd0) & (rword == 2'd1) & wbs_sel_i[0];
    cfg0_wr = wr & (bank == 2'd0) & (rword == 2'd2);
    cfg1_wr = wr & (bank == 2'd0) & (rword == 2'd3);

    soft_req  = ctrl_wr & wbs_dat_i[1];
    start_req = ctrl_wr & wbs_dat_i[0] & ~wbs_dat_i[1];

    img_we         = wr & (bank == 2'd1) & ~busy_q;
    kern_we        = wr & (bank == 2'd2) & ~busy_q;
    eng_start      = start_req & ~busy_q;
    eng_soft_reset = soft_req;
    err_set = (start_req & busy_q)
            | (wr & ((bank == 2'd1) | (bank == 2'd2)) & busy_q)
            | (wr & (bank == 2'd3));

    irq_en_d = ctrl_wr ? wbs_dat_i[2] : irq_en_q;
    cfg0_d   = cfg0_q;
    cfg1_d   = cfg1_q;
    for (int b = 0; b < 4; b++) begin
      if (cfg0_wr && wbs_sel_i[b]) cfg0_d[8*b +: 8] = wbs_dat_i[8*b +: 8];
      if (cfg1_wr && wbs_sel_i[b]) cfg1_d[8*b +: 8] = wbs_dat_i[8*b +: 8];
    end

    busy_d = busy_q;
    if (eng_done)  busy_d = 1'b0;
    if (eng_start) busy_d = 1'b1;
    if (soft_req)  busy_d = 1'b0;

    // A completion in the same cycle as a W1C of done must leave done set.
    done_d = done_q;
    if (stat_wr && wbs_dat_i[1]) done_d = 1'b0;
    if (eng_start)               done_d = 1'b0;
    if (eng_done)                done_d = 1'b1;

    err_d = err_q;
    if (stat_wr && wbs_dat_i[2]) err_d = 1'b0;
    if (err_set)                 err_d = 1'b1;

    case (rword)
      2'd0:    reg_rdat = {29'd0, irq_en_q, 2'b00};
      2'd1:    reg_rdat = {29'd0, err_q, done_q, busy_q};
      2'd2:    reg_rdat = cfg0_q;
      default: reg_rdat = cfg1_q;
    endcase
    res_ext = 32'(res_rdat);

    state_d = state_q;
    cnt_d   = cnt_q;
    rdat_d  = rdat_q;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          if (rd && (bank == 2'd3) && (RD_LAT > 0)) begin
            state_d = S_RD_WAIT;
            cnt_d   = CNT_W'(RD_LAT - 1);
          end else begin
            state_d = S_ACK;
            if (!rd)               rdat_d = 32'd0;
            else if (bank == 2'd0) rdat_d = reg_rdat;
            else if (bank == 2'd3) rdat_d = res_ext;
            else                   rdat_d = 32'd0;
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == '0) begin
          rdat_d  = res_ext;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    ack_d = (state_d == S_ACK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rdat_q   <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_en_q <= 1'b0;
      cfg0_q   <= '0;
      cfg1_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdat_q   <= rdat_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      irq_en_q <= irq_en_d;
      cfg0_q   <= cfg0_d;
      cfg1_q   <= cfg1_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
  assign ram_wadr  = wbs_adr_i[RAM_AW+1:2];
  assign res_radr  = wbs_adr_i[RAM_AW+1:2];
  assign ram_wdat  = wbs_dat_i[IMG_DW-1:0];
  assign cfg0      = cfg0_q;
  assign cfg1      = cfg1_q;
  assign irq       = irq_en_q & done_q;

endmodule

// File: tb/tb_conv_wb_bridge.sv
// Directed bench for conv_wb_bridge: vector table of bus transactions plus
// hand sequences for wrong window, done/W1C collision and mid-transaction reset.
module tb_conv_wb_bridge;
  localparam int RD_LAT = 2;
  localparam logic [31:0] CTRL = 32'h3000_0000, STAT = 32'h3000_0004,
                          CFG0 = 32'h3000_0008, CFG1 = 32'h3000_000C,
                          IMG5 = 32'h3000_0114, KRN3 = 32'h3000_020C,
                          RES7 = 32'h3000_031C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        cyc = 0, stb = 0, we = 0;
  logic [3:0]  sel = 0;
  logic [31:0] adr = 0, dat = 0;
  logic        ack;
  logic [31:0] rdo;
  logic        img_we, kern_we, eng_start, eng_soft_reset, irq;
  logic        eng_done = 1'b0;
  logic [5:0]  ram_wadr, res_radr;
  logic [23:0] ram_wdat;
  logic [7:0]  res_rdat;
  logic [31:0] cfg0, cfg1;

  conv_wb_bridge #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(rdo),
    .img_we(img_we), .kern_we(kern_we), .ram_wadr(ram_wadr), .ram_wdat(ram_wdat),
    .res_radr(res_radr), .res_rdat(res_rdat),
    .eng_start(eng_start), .eng_soft_reset(eng_soft_reset), .eng_done(eng_done),
    .cfg0(cfg0), .cfg1(cfg1), .irq(irq)
  );

  // Result RAM model with a two-cycle read pipeline.
  logic [7:0] mem [64];
  logic [7:0] rp1 = 0, rp2 = 0;
  always @(posedge clk) begin
    rp1 <= mem[res_radr];
    rp2 <= rp1;
  end
  assign res_rdat = rp2;

  int n_img = 0, n_kern = 0, n_start = 0, n_soft = 0;
  logic [5:0]  last_wadr = 0;
  logic [23:0] last_wdat = 0;
  always @(negedge clk) begin
    if (img_we) begin n_img++; last_wadr = ram_wadr; last_wdat = ram_wdat; end
    if (kern_we) n_kern++;
    if (eng_start) n_start++;
    if (eng_soft_reset) n_soft++;
  end

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one transaction from just after a rising edge; lat = -1 if never acked.
  task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rdat, output int lat);
    bit got = 0;
    cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
    lat = 0; rdat = 32'd0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ack) begin got = 1; rdat = rdo; end
    end
    cyc = 0; stb = 0; we = 0;
    if (!got) lat = -1;
    @(posedge clk); #1;
    if (got) check("ack_single_cycle", {31'd0, ack}, 32'd0);
  endtask

  typedef struct {
    string       name;
    bit          w;
    logic [31:0] a, d;
    logic [3:0]  s;
    bit          pre_done;
    logic [31:0] exp_rd;
    int          exp_lat, d_img, d_kern, d_start, d_soft;
    bit          exp_irq;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input string n, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input bit pd, input logic [31:0] er, input int el,
                     input int di, input int dk, input int dst, input int dso, input bit ei);
    vec_t v;
    v.name = n; v.w = w; v.a = a; v.d = d; v.s = s; v.pre_done = pd; v.exp_rd = er;
    v.exp_lat = el; v.d_img = di; v.d_kern = dk; v.d_start = dst; v.d_soft = dso;
    v.exp_irq = ei;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] rd;
    int lat, i0, k0, s0, r0, acks;

    for (int i = 0; i < 64; i++) mem[i] = 8'(i * 3 + 1);
    mem[7] = 8'h9C;

    //    name          w  addr  data          sel    pd rd            lat img kern st so irq
    add("rd_status0",   0, STAT, 32'h0,        4'hF, 0, 32'h0,        1, 0, 0, 0, 0, 0);
    add("wr_ctrl_5",    1, CTRL, 32'h5,        4'hF, 0, 32'h0,        1, 0, 0, 1, 0, 0);
    add("rd_status_b",  0, STAT, 32'h0,        4'hF, 0, 32'h1,        1, 0, 0, 0, 0, 0);
    add("rd_ctrl",      0, CTRL, 32'h0,        4'hF, 0, 32'h4,        1, 0, 0, 0, 0, 0);
    add("rd_status_dn", 0, STAT, 32'h0,        4'hF, 1, 32'h2,        1, 0, 0, 0, 0, 1);
    add("w1c_done",     1, STAT, 32'h2,        4'hF, 0, 32'h0,        1, 0, 0, 0, 0, 0);
    add("rd_status_c",  0, STAT, 32'h0,        4'hF, 0, 32'h0,        1, 0, 0, 0, 0, 0);
    add("wr_ctrl_1",    1, CTRL, 32'h1,        4'hF, 0, 32'h0,        1, 0, 0, 1, 0, 0);
    add("wr_kern_busy", 1, KRN3, 32'h123456,   4'hF, 0, 32'h0,        1, 0, 0, 0, 0, 0);
    add("wr_ctrl_busy", 1, CTRL, 32'h1,        4'hF, 0, 32'h0,        1, 0, 0, 0, 0, 0);
    add("rd_status_be", 0, STAT, 32'h0,        4'hF, 0, 32'h5,        1, 0, 0, 0, 0, 0);
    add("w1c_err",      1, STAT, 32'h4,        4'hF, 0, 32'h0,        1, 0, 0, 0, 0, 0);
    add("rd_status_d",  0, STAT, 32'h0,        4'hF, 0, 32'h1,        1, 0, 0, 0, 0, 0);
    add("wr_ctrl_3",    1, CTRL, 32'h3,        4'hF, 0, 32'h0,        1, 0, 0, 0, 1, 0);
    add("rd_status_sr", 0, STAT, 32'h0,        4'hF, 0, 32'h0,        1, 0, 0, 0, 0, 0);
    add("wr_cfg0_sel",  1, CFG0, 32'hFFFFFFFF, 4'h2, 0, 32'h0,        1, 0, 0, 0, 0, 0);
    add("rd_cfg0",      0, CFG0, 32'h0,        4'hF, 0, 32'h0000FF00, 1, 0, 0, 0, 0, 0);
    add("wr_cfg1",      1, CFG1, 32'h12345678, 4'hF, 0, 32'h0,        1, 0, 0, 0, 0, 0);
    add("rd_cfg1",      0, CFG1, 32'h0,        4'hF, 0, 32'h12345678, 1, 0, 0, 0, 0, 0);
    add("wr_bank3",     1, RES7, 32'h55,       4'hF, 0, 32'h0,        1, 0, 0, 0, 0, 0);
    add("rd_status_e",  0, STAT, 32'h0,        4'hF, 0, 32'h4,        1, 0, 0, 0, 0, 0);
    add("rd_img_zero",  0, IMG5, 32'h0,        4'hF, 0, 32'h0,        1, 0, 0, 0, 0, 0);
    add("rd_result7",   0, RES7, 32'h0,        4'hF, 0, 32'h0000009C, 3, 0, 0, 0, 0, 0);
    add("w1c_err2",     1, STAT, 32'h4,        4'hF, 0, 32'h0,        1, 0, 0, 0, 0, 0);
    add("rd_status_f",  0, STAT, 32'h0,        4'hF, 0, 32'h0,        1, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1 reset = 0;
    check("reset_ack", {31'd0, ack}, 32'd0);
    check("reset_dat", rdo, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_cfg0", cfg0, 32'd0);
    check("reset_cfg1", cfg1, 32'd0);

    bus(0, 32'h3100_0004, 32'h0, 4'hF, rd, lat);
    check("wrong_window_noack", 32'(lat), 32'(-1));

    foreach (tbl[v]) begin
      if (tbl[v].pre_done) begin
        eng_done = 1; @(posedge clk); #1 eng_done = 0;
      end
      i0 = n_img; k0 = n_kern; s0 = n_start; r0 = n_soft;
      bus(tbl[v].w, tbl[v].a, tbl[v].d, tbl[v].s, rd, lat);
      check({tbl[v].name, "_lat"}, 32'(lat), 32'(tbl[v].exp_lat));
      if (!tbl[v].w) check({tbl[v].name, "_rdata"}, rd, tbl[v].exp_rd);
      check({tbl[v].name, "_img_we"}, 32'(n_img - i0), 32'(tbl[v].d_img));
      check({tbl[v].name, "_kern_we"}, 32'(n_kern - k0), 32'(tbl[v].d_kern));
      check({tbl[v].name, "_start"}, 32'(n_start - s0), 32'(tbl[v].d_start));
      check({tbl[v].name, "_soft"}, 32'(n_soft - r0), 32'(tbl[v].d_soft));
      check({tbl[v].name, "_irq"}, {31'd0, irq}, {31'd0, tbl[v].exp_irq});
    end
    check("cfg0_port", cfg0, 32'h0000FF00);

    // Image write: one strobe with the decoded word address and truncated data.
    i0 = n_img;
    bus(1, IMG5, 32'h00ABCDEF, 4'h0, rd, lat);
    check("img_lat", 32'(lat), 32'd1);
    check("img_we_count", 32'(n_img - i0), 32'd1);
    check("img_wadr", 32'(last_wadr), 32'd5);
    check("img_wdat", 32'(last_wdat), 32'h00ABCDEF);

    // Completion colliding with a W1C of done leaves done set.
    bus(1, CTRL, 32'h1, 4'hF, rd, lat);
    eng_done = 1; @(posedge clk); #1 eng_done = 0;
    fork
      bus(1, STAT, 32'h2, 4'hF, rd, lat);
      begin eng_done = 1; @(posedge clk); #1 eng_done = 0; end
    join
    bus(0, STAT, 32'h0, 4'hF, rd, lat);
    check("done_set_wins", rd, 32'h2);

    // Reset while waiting on a result read: no ack ever appears.
    cyc = 1; stb = 1; we = 0; adr = RES7; sel = 4'hF;
    @(posedge clk); #1;
    reset = 1; cyc = 0; stb = 0;
    @(posedge clk); #1;
    reset = 0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      if (ack) acks++;
      @(posedge clk); #1;
    end
    check("midreset_noack", 32'(acks), 32'd0);
    check("midreset_cfg0", cfg0, 32'd0);
    bus(0, STAT, 32'h0, 4'hF, rd, lat);
    check("midreset_status", rd, 32'd0);
    check("midreset_status_lat", 32'(lat), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_wb_bridge.md
# conv_wb_bridge

Parametrised Wishbone-slave front end for the convolution accelerator. It decodes a programmable address window into a control/status register file, image and kernel RAM write ports, and a result RAM read port. It also sequences engine start/soft-reset/done through a busy/done/error state model with a level interrupt. Unlike the previous top, it has an explicit ack FSM, configurable RAM read latency, write lockout while busy, and sticky error reporting.

## Interface
Parameters:
- MY_ADDR, 8'h30, window id compared against wbs_adr_i[ADDR_MSB-1:ADDR_LSB]
- ADDR_MSB, 32, window field MSB+1
- ADDR_LSB, 24, window field LSB
- BANK_LSB, 8, bank select = wbs_adr_i[BANK_LSB+1:BANK_LSB]
- IMG_DW, 24, image/kernel RAM data width (≤32)
- RAM_AW, 6, word-address width of all RAMs; word index = wbs_adr_i[RAM_AW+1:2], requires RAM_AW+2 ≤ BANK_LSB
- RSLT_DW, 8, result RAM data width
- RD_LAT, 1, result RAM read latency in cycles (0 = asynchronous read)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone control
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  single-cycle ack
- wbs_dat_o  out  32  read data, valid with ack
- img_we, kern_we  out  1  RAM write strobes
- ram_wadr  out  RAM_AW  shared write address
- ram_wdat  out  IMG_DW  shared write data = wbs_dat_i[IMG_DW-1:0]
- res_radr  out  RAM_AW  result read address (combinational from wbs_adr_i)
- res_rdat  in  RSLT_DW  result read data
- eng_start  out  1  one-cycle start pulse
- eng_soft_reset  out  1  one-cycle engine reset pulse
- eng_done  in  1  engine completion pulse
- cfg0, cfg1  out  32  engine configuration words
- irq  out  1  level interrupt

## Operation
- valid = window match & cyc & stb. Address mismatch: never acked.
- Banks: 0 regs, 1 image RAM (write-only), 2 kernel RAM (write-only), 3 result RAM (read-only).
- Register words (adr[3:2]):
  - 0 CTRL: bit0 start (self-clearing), bit1 soft_reset (self-clearing), bit2 irq_en (stored).
  - 1 STATUS: bit0 busy (RO); bit1 done, sticky, W1C; bit2 err, sticky, W1C.
  - 2 CFG0; 3 CFG1.
- Register writes honour wbs_sel_i per byte. RAM writes ignore sel.
- Ack FSM states:
  - IDLE: on valid, perform the write side effect in this cycle. Go to RD_WAIT if it is a result read and RD_LAT>0; otherwise go to ACK.
  - RD_WAIT: count RD_LAT-1 further cycles, then capture res_rdat (zero-extended) and go to ACK.
  - ACK: assert ack for exactly one cycle, then return to IDLE.
- Start:
  - start=1 while not busy → eng_start pulse, busy←1, done←0.
  - start=1 while busy → ignored, err←1.
- eng_done → busy←0, done←1. If eng_done coincides with a W1C of done, set wins.
- soft_reset=1 → eng_soft_reset pulse, busy←0. done and err are unchanged.
- If start and soft_reset are written in the same word, soft_reset wins and no start is issued.
- Image/kernel write while busy → no RAM strobe, err←1, still acked.
- Write to bank 3 → no effect, err←1, acked.
- Read of bank 1/2 → returns 0, acked.
- irq = irq_en & done.

## Timing
- Reset values: ack, dat_o, all strobes and pulses, cfg0/1, irq_en, busy, done, err, irq = 0. FSM enters IDLE.
- Transaction accepted in cycle N:
  - Write, or register read: ack in N+1. Register read data is sampled in N.
  - Result read: res_rdat is sampled at the end of N+max(RD_LAT,0) and ack is asserted in N+RD_LAT+1. The master must hold the address until ack.
- img_we/kern_we/eng_start/eng_soft_reset are asserted only in cycle N and never repeat for one transaction.
- No new transaction is accepted in ACK or RD_WAIT. The next acceptance is possible in the cycle after ACK.
- Reset mid-transaction: FSM returns to IDLE and no ack is issued.

## Test plan
- Reset, then read STATUS → ack in 1 cycle, data 0. Read with a wrong window id (8'h31) → no ack within 20 cycles.
- Write image word 5 = 0x00ABCDEF → img_we pulse for one cycle with ram_wadr=5, ram_wdat=0xABCDEF. Ack the next cycle.
- Write CTRL=0x5 → eng_start pulse and STATUS=0x1. Pulse eng_done → STATUS=0x2, irq=1. Write STATUS=0x2 → irq=0.
- While busy, write kernel word 3, then CTRL=0x1 → no kern_we and no second eng_start, STATUS=0x5. W1C 0x4 → err cleared.
- With RD_LAT=2 and result word 7=0x9C, read bank 3 offset 0x1C → ack 3 cycles after accept, dat_o=0x0000009C.
- Byte-select write CFG0 sel=4'b0010 data=0xFFFFFFFF over 0 → CFG0=0x0000FF00. eng_done coinciding with a W1C of done → done stays 1.
